// File: rtl/bht_sat_predictor_if.sv
// Predict/update/statistics bundle for the branch history table.
// The requester (fetch / branch resolve) owns the master side; the table is the slave.
interface bht_sat_predictor_if #(
    parameter int PC_BITS   = 9,
    parameter int IDX_BITS  = 4,
    parameter int STAT_BITS = 16
);
    logic                 pred_valid;
    logic [PC_BITS-1:0]   pred_pc;
    logic                 pred_out_valid;
    logic                 pred_taken;
    logic [IDX_BITS-1:0]  pred_idx;

    logic                 upd_valid;
    logic [IDX_BITS-1:0]  upd_idx;
    logic                 upd_taken;
    logic                 upd_pred;

    logic [STAT_BITS-1:0] stat_updates;
    logic [STAT_BITS-1:0] stat_mispred;

    modport master (
        output pred_valid, pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
        input  pred_out_valid, pred_taken, pred_idx, stat_updates, stat_mispred
    );

    modport slave (
        input  pred_valid, pred_pc, upd_valid, upd_idx, upd_taken, upd_pred,
        output pred_out_valid, pred_taken, pred_idx, stat_updates, stat_mispred
    );
endinterface

// File: rtl/bht_sat_predictor.sv
// Branch history table of saturating counters with bimodal or gshare indexing,
// a one-cycle registered prediction port, a resolve-time update port and statistics.

// One saturating counter; resets/clears to weakly-not-taken.
module bht_sat_ctr #(
    parameter int CTR_BITS = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear,
    input  logic                upd_en,
    input  logic                upd_taken,
    output logic [CTR_BITS-1:0] ctr
);
    localparam logic [CTR_BITS-1:0] WNT     = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;

    logic [CTR_BITS-1:0] ctr_q, ctr_d;

    always_comb begin
        ctr_d = ctr_q;
        if (clear) begin
            ctr_d = WNT;
        end else if (upd_en) begin
            if (upd_taken && ctr_q != CTR_MAX)
                ctr_d = ctr_q + CTR_BITS'(1);
            else if (!upd_taken && ctr_q != '0)
                ctr_d = ctr_q - CTR_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ctr_q <= WNT;
        else          ctr_q <= ctr_d;
    end

    assign ctr = ctr_q;
endmodule

module bht_sat_predictor #(
    parameter int ENTRIES   = 16,
    parameter int CTR_BITS  = 2,
    parameter int PC_BITS   = 9,
    parameter int MODE      = 0,
    parameter int HIST_BITS = 4,
    parameter int STAT_BITS = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    bht_sat_predictor_if.slave    bus
);
    localparam int IDX_BITS = $clog2(ENTRIES);

    typedef struct packed {
        logic                valid;
        logic [IDX_BITS-1:0] idx;
        logic                taken;
        logic                pred;
    } upd_req_t;

    upd_req_t                           upd_req;
    logic [ENTRIES-1:0][CTR_BITS-1:0]   ctr_all;
    logic [IDX_BITS-1:0]                hist_ext;
    logic [IDX_BITS-1:0]                pred_idx_w;
    logic                               unused_pc;

    logic                  pred_out_valid_q, pred_out_valid_d;
    logic                  pred_taken_q,     pred_taken_d;
    logic [IDX_BITS-1:0]   pred_idx_q,       pred_idx_d;
    logic [HIST_BITS-1:0]  ghr_q,            ghr_d;
    logic [STAT_BITS-1:0]  stat_updates_q,   stat_updates_d;
    logic [STAT_BITS-1:0]  stat_mispred_q,   stat_mispred_d;

    // clear swallows any update presented in the same cycle
    assign upd_req = '{valid: bus.upd_valid & ~clear,
                       idx:   bus.upd_idx,
                       taken: bus.upd_taken,
                       pred:  bus.upd_pred};

    assign unused_pc = ^bus.pred_pc;
    assign hist_ext  = IDX_BITS'(ghr_q);
    assign pred_idx_w = bus.pred_pc[IDX_BITS-1:0] ^ ((MODE == 1) ? hist_ext : '0);

    for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
        bht_sat_ctr #(.CTR_BITS(CTR_BITS)) u_ctr (
            .clk       (clk),
            .reset_n   (reset_n),
            .clear     (clear),
            .upd_en    (upd_req.valid && (upd_req.idx == IDX_BITS'(e))),
            .upd_taken (upd_req.taken),
            .ctr       (ctr_all[e])
        );
    end

    // Prediction reads the registered table and GHR, so a same-cycle update is not seen.
    always_comb begin
        pred_out_valid_d = bus.pred_valid & ~clear;
        pred_taken_d     = pred_taken_q;
        pred_idx_d       = pred_idx_q;
        if (clear) begin
            pred_taken_d = 1'b0;
            pred_idx_d   = '0;
        end else if (bus.pred_valid) begin
            pred_taken_d = ctr_all[pred_idx_w][CTR_BITS-1];
            pred_idx_d   = pred_idx_w;
        end
    end

    always_comb begin
        ghr_d          = ghr_q;
        stat_updates_d = stat_updates_q;
        stat_mispred_d = stat_mispred_q;
        if (clear) begin
            ghr_d          = '0;
            stat_updates_d = '0;
            stat_mispred_d = '0;
        end else if (upd_req.valid) begin
            if (MODE == 1)
                ghr_d = HIST_BITS'({ghr_q, upd_req.taken});
            stat_updates_d = stat_updates_q + STAT_BITS'(1);
            if (upd_req.pred != upd_req.taken)
                stat_mispred_d = stat_mispred_q + STAT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pred_out_valid_q <= 1'b0;
            pred_taken_q     <= 1'b0;
            pred_idx_q       <= '0;
            ghr_q            <= '0;
            stat_updates_q   <= '0;
            stat_mispred_q   <= '0;
        end else begin
            pred_out_valid_q <= pred_out_valid_d;
            pred_taken_q     <= pred_taken_d;
            pred_idx_q       <= pred_idx_d;
            ghr_q            <= ghr_d;
            stat_updates_q   <= stat_updates_d;
            stat_mispred_q   <= stat_mispred_d;
        end
    end

    assign bus.pred_out_valid = pred_out_valid_q;
    assign bus.pred_taken     = pred_taken_q;
    assign bus.pred_idx       = pred_idx_q;
    assign bus.stat_updates   = stat_updates_q;
    assign bus.stat_mispred   = stat_mispred_q;
endmodule

// File: tb/tb_bht_sat_predictor.sv
// Directed bench: three table configurations (2-bit bimodal, 1-bit with narrow stats,
// 2-bit gshare) driven from one linear sequence with hand-computed expectations.
module tb_bht_sat_predictor;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic clear = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bht_sat_predictor_if #(.PC_BITS(9), .IDX_BITS(4), .STAT_BITS(16)) bus_a ();
    bht_sat_predictor_if #(.PC_BITS(9), .IDX_BITS(4), .STAT_BITS(3))  bus_b ();
    bht_sat_predictor_if #(.PC_BITS(9), .IDX_BITS(4), .STAT_BITS(16)) bus_c ();

    bht_sat_predictor #(.ENTRIES(16), .CTR_BITS(2), .PC_BITS(9), .MODE(0),
                        .HIST_BITS(4), .STAT_BITS(16))
        u_a (.clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus_a));
    bht_sat_predictor #(.ENTRIES(16), .CTR_BITS(1), .PC_BITS(9), .MODE(0),
                        .HIST_BITS(4), .STAT_BITS(3))
        u_b (.clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus_b));
    bht_sat_predictor #(.ENTRIES(16), .CTR_BITS(2), .PC_BITS(9), .MODE(1),
                        .HIST_BITS(4), .STAT_BITS(16))
        u_c (.clk(clk), .reset_n(reset_n), .clear(clear), .bus(bus_c));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic a_upd(input logic [3:0] idx, input logic t, input logic p);
        bus_a.upd_valid = 1'b1; bus_a.upd_idx = idx; bus_a.upd_taken = t; bus_a.upd_pred = p;
        tick();
        bus_a.upd_valid = 1'b0;
    endtask

    task automatic a_pred(input logic [8:0] pc);
        bus_a.pred_valid = 1'b1; bus_a.pred_pc = pc;
        tick();
        bus_a.pred_valid = 1'b0;
    endtask

    task automatic b_upd(input logic [3:0] idx, input logic t, input logic p);
        bus_b.upd_valid = 1'b1; bus_b.upd_idx = idx; bus_b.upd_taken = t; bus_b.upd_pred = p;
        tick();
        bus_b.upd_valid = 1'b0;
    endtask

    task automatic b_pred(input logic [8:0] pc);
        bus_b.pred_valid = 1'b1; bus_b.pred_pc = pc;
        tick();
        bus_b.pred_valid = 1'b0;
    endtask

    task automatic c_upd(input logic [3:0] idx, input logic t);
        bus_c.upd_valid = 1'b1; bus_c.upd_idx = idx; bus_c.upd_taken = t; bus_c.upd_pred = 1'b0;
        tick();
        bus_c.upd_valid = 1'b0;
    endtask

    task automatic c_pred(input logic [8:0] pc);
        bus_c.pred_valid = 1'b1; bus_c.pred_pc = pc;
        tick();
        bus_c.pred_valid = 1'b0;
    endtask

    initial begin
        bus_a.pred_valid = 0; bus_a.pred_pc = '0; bus_a.upd_valid = 0;
        bus_a.upd_idx = '0; bus_a.upd_taken = 0; bus_a.upd_pred = 0;
        bus_b.pred_valid = 0; bus_b.pred_pc = '0; bus_b.upd_valid = 0;
        bus_b.upd_idx = '0; bus_b.upd_taken = 0; bus_b.upd_pred = 0;
        bus_c.pred_valid = 0; bus_c.pred_pc = '0; bus_c.upd_valid = 0;
        bus_c.upd_idx = '0; bus_c.upd_taken = 0; bus_c.upd_pred = 0;

        #12;
        check("rst_pov",   bus_a.pred_out_valid, 0);
        check("rst_taken", bus_a.pred_taken, 0);
        check("rst_idx",   bus_a.pred_idx, 0);
        check("rst_upd",   bus_a.stat_updates, 0);
        check("rst_mis",   bus_a.stat_mispred, 0);
        reset_n = 1'b1;
        tick();

        // T1: first prediction from the reset table
        bus_a.pred_valid = 1; bus_a.pred_pc = 9'h005;
        bus_c.pred_valid = 1; bus_c.pred_pc = 9'h005;
        tick();
        check("t1_pov",   bus_a.pred_out_valid, 1);
        check("t1_idx",   bus_a.pred_idx, 5);
        check("t1_taken", bus_a.pred_taken, 0);
        check("t1_c_idx", bus_c.pred_idx, 5);
        bus_a.pred_valid = 0; bus_c.pred_valid = 0;
        tick();
        check("t1_pov_drop", bus_a.pred_out_valid, 0);
        check("t1_idx_hold", bus_a.pred_idx, 5);

        // T2: idx3 1->2->3->3, then 2, then 1
        a_upd(4'd3, 1, 0);
        a_upd(4'd3, 1, 1);
        a_upd(4'd3, 1, 1);
        a_pred(9'd3);
        check("t2_sat_taken", bus_a.pred_taken, 1);
        check("t2_idx", bus_a.pred_idx, 3);
        a_upd(4'd3, 0, 1);
        a_pred(9'd3);
        check("t2_ctr2_taken", bus_a.pred_taken, 1);
        a_upd(4'd3, 0, 1);
        a_pred(9'd3);
        check("t2_ctr1_taken", bus_a.pred_taken, 0);
        check("t2_upd", bus_a.stat_updates, 5);
        check("t2_mis", bus_a.stat_mispred, 3);

        // T3: 1-bit counters follow the last outcome
        b_upd(4'd7, 1, 0);
        b_pred(9'd7);
        check("t3_p1", bus_b.pred_taken, 1);
        b_upd(4'd7, 0, 1);
        b_pred(9'd7);
        check("t3_p2", bus_b.pred_taken, 0);
        b_upd(4'd7, 1, 0);
        b_pred(9'd7);
        check("t3_p3", bus_b.pred_taken, 1);
        for (int i = 0; i < 6; i++) b_upd(4'd0, 0, 0);
        check("b_upd_wrap", bus_b.stat_updates, 1);
        check("b_mis", bus_b.stat_mispred, 3);

        // T4: gshare history shifts in resolved outcomes
        c_upd(4'd0, 1);
        c_pred(9'h005);
        check("t4_ghr1", bus_c.pred_idx, 4);
        c_upd(4'd0, 1);
        c_pred(9'h005);
        check("t4_ghr3", bus_c.pred_idx, 6);
        c_upd(4'd0, 0);
        c_pred(9'h005);
        check("t4_ghr6", bus_c.pred_idx, 3);

        // T5: same-cycle predict and update on idx2 (ctr=1)
        bus_a.pred_valid = 1; bus_a.pred_pc = 9'd2;
        bus_a.upd_valid = 1; bus_a.upd_idx = 4'd2; bus_a.upd_taken = 1; bus_a.upd_pred = 0;
        tick();
        bus_a.upd_valid = 0;
        check("t5_rbw", bus_a.pred_taken, 0);
        check("t5_idx", bus_a.pred_idx, 2);
        tick();
        bus_a.pred_valid = 0;
        check("t5_after", bus_a.pred_taken, 1);

        // idx4 to strongly taken, then clear with competing requests
        a_upd(4'd4, 1, 1);
        a_upd(4'd4, 1, 1);
        check("pre_clr_upd", bus_a.stat_updates, 8);
        check("pre_clr_mis", bus_a.stat_mispred, 4);
        clear = 1;
        bus_a.pred_valid = 1; bus_a.pred_pc = 9'd4;
        bus_a.upd_valid = 1; bus_a.upd_idx = 4'd4; bus_a.upd_taken = 1; bus_a.upd_pred = 0;
        tick();
        clear = 0; bus_a.pred_valid = 0; bus_a.upd_valid = 0;
        check("clr_pov", bus_a.pred_out_valid, 0);
        check("clr_idx", bus_a.pred_idx, 0);
        check("clr_upd", bus_a.stat_updates, 0);
        check("clr_mis", bus_a.stat_mispred, 0);
        a_pred(9'd4);
        check("clr_ctr_wnt", bus_a.pred_taken, 0);

        // T6: five updates on idx8, two mispredicted; ctr 1->2->1->2->1->2
        a_upd(4'd8, 1, 1);
        a_upd(4'd8, 0, 1);
        a_upd(4'd8, 1, 1);
        a_upd(4'd8, 0, 0);
        a_upd(4'd8, 1, 0);
        check("t6_upd", bus_a.stat_updates, 5);
        check("t6_mis", bus_a.stat_mispred, 2);
        a_pred(9'd8);
        check("t6_taken", bus_a.pred_taken, 1);

        // async reset with a request in flight
        bus_a.pred_valid = 1; bus_a.pred_pc = 9'd8;
        tick();
        check("ar_pov_pre", bus_a.pred_out_valid, 1);
        reset_n = 0;
        #2;
        check("ar_pov", bus_a.pred_out_valid, 0);
        check("ar_upd", bus_a.stat_updates, 0);
        check("ar_mis", bus_a.stat_mispred, 0);
        tick();
        reset_n = 1;
        tick();
        bus_a.pred_valid = 0;
        check("ar_ctr_wnt", bus_a.pred_taken, 0);
        check("ar_pov_post", bus_a.pred_out_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
